bytecode_fetch: RTL and testbench
=================================

Name: bytecode_fetch

Overview:
- Instruction fetch unit feeding the bytecode decoder.
- Reads JVM bytecode bytes from synchronous program memory and assembles each instruction (opcode plus 0-2 operand bytes).
- Presents each instruction over a valid/ready handshake to the control path, tracks the program counter, and redirects on GOTO or taken conditional branches.
- Stops on return opcodes.

Parameters:
- ADDR_W, 12, program memory byte-address width; all PC arithmetic is modulo 2^ADDR_W.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse: begin fetching at start_addr
- start_addr  in  ADDR_W  first instruction address
- mem_rd  out  1  program memory read strobe
- mem_addr  out  ADDR_W  program memory byte address
- mem_data  in  8  read data, valid exactly 1 cycle after mem_rd
- instr_valid  out  1  instruction presented
- instr_ready  in  1  consumer accepts instruction
- opcode  out  8  instruction opcode
- arg  out  16  raw operands: 1-byte → {8'h00,b1}; 2-byte → {b1,b2}; none → 0
- instr_pc  out  ADDR_W  address of the presented opcode
- branch_taken  in  1  conditional branch outcome, sampled only in the handshake cycle
- busy  out  1  high in every state except IDLE/HALT
- halted  out  1  high in HALT
- illegal  out  1  illegal-opcode flag (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; pc=0; all outputs 0.
  - Reset mid-fetch abandons the instruction; no instr_valid glitch.
- Operand count (argc):
  - 2 for SIPUSH 0x11, IINC 0x84, 0x99-0xA7 (IFcond, IF_ICMPcond, GOTO).
  - 1 for BIPUSH 0x10, LDC 0x12, ILOAD 0x15, ISTORE 0x36, NEWARRAY 0xBC.
  - 0 otherwise.
- Instruction length = 1+argc.
- States:
  - IDLE: start=1 → pc<=start_addr, go OP_REQ.
  - OP_REQ: mem_rd=1, mem_addr=pc → OP_CAP.
  - OP_CAP: latch opcode=mem_data.
    - argc>0: mem_rd=1, addr=pc+1 → A1_CAP.
    - argc=0: → ISSUE.
  - A1_CAP: latch b1.
    - argc=2: mem_rd=1, addr=pc+2 → A2_CAP.
    - argc=1: → ISSUE.
  - A2_CAP: latch b2 → ISSUE.
  - ISSUE: instr_valid=1. opcode/arg/instr_pc stable until handshake (valid&&ready). On handshake:
    - Return opcodes (IRETURN 0xAC, ARETURN 0xB0, RETURN 0xB1) → HALT.
    - GOTO (0xA7), or 0x99-0xA6 with branch_taken=1 → pc<=instr_pc+signed(arg).
    - Otherwise → pc<=instr_pc+len.
    - Non-halting cases → OP_REQ.
  - HALT: halted=1; start=1 restarts exactly as from IDLE.
- Timing:
  - Latency from start to instr_valid is 3/4/5 cycles for argc 0/1/2.
  - Throughput with ready held high: one instruction per 3/4/5 cycles.
- start is ignored while busy.
- branch_taken is ignored for non-branch opcodes and for GOTO.
- PC wrap: 0xFFF+1 → 0x000 at ADDR_W=12. Operand reads also wrap.
- mem_rd is never asserted in IDLE, ISSUE or HALT.

Optional Feature:
- FETCH_ILLEGAL_EN defined:
  - In OP_CAP, an opcode outside the supported set (package list) skips operand fetch and never asserts instr_valid.
  - It goes to HALT with illegal=1 and instr_pc=its address.
  - illegal clears on start.
- Not defined: every opcode is issued (unknown → argc 0); illegal tied 0.

Decomposition:
- bytecode_pkg holds:
  - opcode localparams
  - fetch_state_t enum (IDLE, OP_REQ, OP_CAP, A1_CAP, A2_CAP, ISSUE, HALT)
  - supported-opcode list
  - is_return/is_branch helpers
- Sub-module bytecode_len: combinational opcode → argc[1:0], is_branch, is_goto, is_return, is_legal.

Test Plan:
- Reset then start_addr=0x010, memory {0x04,0x05,0x60}, ready=1 → three issues at cycles 3, 6, 9 with opcode 0x04/0x05/0x60, instr_pc 0x010/0x011/0x012, arg 0.
- Memory @0x000 {0x11,0x12,0x34} → opcode 0x11, arg=0x1234, next fetch at 0x003. Memory @0x000 {0x10,0xFF} → arg=0x00FF, next fetch at 0x002.
- GOTO @0x020 {0xA7,0xFF,0xFC} → next mem_addr 0x01C. IFEQ @0x030 {0x99,0x00,0x08}: branch_taken=1 → 0x038; branch_taken=0 → 0x033.
- Hold ready=0 for 5 cycles in ISSUE → outputs stable, no mem_rd; accept on cycle 6. Drop rst_n during A1_CAP → all outputs 0 immediately, state IDLE.
- RETURN 0xB1 → halted=1, busy=0, start ignored while busy earlier; start=1 in HALT → restarts at start_addr. With FETCH_ILLEGAL_EN, opcode 0xFE → illegal=1, no instr_valid.
- start_addr=0xFFF, bytes {0x10 @0xFFF, 0x07 @0x000} → arg=0x0007, next pc 0x001.

Source files
------------

// File: rtl/bytecode_pkg.sv
// Opcode constants, fetch FSM state type and opcode-class helpers shared by the bytecode fetch unit.
// The supported-opcode list is consulted only when FETCH_ILLEGAL_EN is defined.
package bytecode_pkg;

    localparam logic [7:0] OP_NOP      = 8'h00;
    localparam logic [7:0] OP_BIPUSH   = 8'h10;
    localparam logic [7:0] OP_SIPUSH   = 8'h11;
    localparam logic [7:0] OP_LDC      = 8'h12;
    localparam logic [7:0] OP_ILOAD    = 8'h15;
    localparam logic [7:0] OP_ISTORE   = 8'h36;
    localparam logic [7:0] OP_IINC     = 8'h84;
    localparam logic [7:0] OP_IFEQ     = 8'h99;
    localparam logic [7:0] OP_IF_LAST  = 8'hA6;
    localparam logic [7:0] OP_GOTO     = 8'hA7;
    localparam logic [7:0] OP_IRETURN  = 8'hAC;
    localparam logic [7:0] OP_ARETURN  = 8'hB0;
    localparam logic [7:0] OP_RETURN   = 8'hB1;
    localparam logic [7:0] OP_NEWARRAY = 8'hBC;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        OP_REQ = 3'd1,
        OP_CAP = 3'd2,
        A1_CAP = 3'd3,
        A2_CAP = 3'd4,
        ISSUE  = 3'd5,
        HALT   = 3'd6
    } fetch_state_t;

    function automatic logic op_is_return(input logic [7:0] op);
        return (op == OP_IRETURN) || (op == OP_ARETURN) || (op == OP_RETURN);
    endfunction

    // Conditional branches plus GOTO; all carry a signed 16-bit offset.
    function automatic logic op_is_branch(input logic [7:0] op);
        return (op >= OP_IFEQ) && (op <= OP_GOTO);
    endfunction

    function automatic logic op_is_supported(input logic [7:0] op);
        logic ok;
        ok = 1'b0;
        case (op) inside
            8'h00, [8'h02:8'h08], 8'h10, 8'h11, 8'h12, 8'h15,
            [8'h1A:8'h1D], 8'h36, [8'h3B:8'h3E], 8'h57, 8'h59,
            8'h60, 8'h64, 8'h68, 8'h84, [8'h99:8'hA7],
            8'hAC, 8'hB0, 8'hB1, 8'hBC: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/bytecode_len.sv
// Combinational opcode classifier: operand count and branch/return/legality flags.
// With FETCH_ILLEGAL_EN defined, is_legal reflects the supported list; otherwise it is always 1.
module bytecode_len
    import bytecode_pkg::*;
(
    input  logic [7:0] op,
    output logic [1:0] argc,
    output logic       is_branch,
    output logic       is_goto,
    output logic       is_return,
    output logic       is_legal
);

    // Operand byte count per opcode; anything unknown is a bare opcode.
    always_comb begin
        argc = 2'd0;
        case (op) inside
            OP_SIPUSH, OP_IINC, [OP_IFEQ:OP_GOTO]:                 argc = 2'd2;
            OP_BIPUSH, OP_LDC, OP_ILOAD, OP_ISTORE, OP_NEWARRAY:   argc = 2'd1;
            default:                                               argc = 2'd0;
        endcase
    end

    assign is_branch = op_is_branch(op);
    assign is_goto   = (op == OP_GOTO);
    assign is_return = op_is_return(op);
`ifdef FETCH_ILLEGAL_EN
    assign is_legal  = op_is_supported(op);
`else
    assign is_legal  = 1'b1;
`endif

endmodule

// File: rtl/bytecode_fetch.sv
// Bytecode fetch unit: reads opcode and operand bytes from synchronous program memory,
// presents each instruction over valid/ready and redirects on branches. Optional: FETCH_ILLEGAL_EN.
module bytecode_fetch
    import bytecode_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [7:0]        opcode,
    output logic [15:0]       arg,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              branch_taken,
    output logic              busy,
    output logic              halted,
    output logic              illegal
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic [7:0]        opcode_q, opcode_d;
    logic [15:0]       arg_q, arg_d;
    logic              illegal_q, illegal_d;

    logic [7:0]        dec_op_s;
    logic [1:0]        argc_s;
    logic              is_branch_s, is_goto_s, is_return_s, is_legal_s;
    logic              mem_rd_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [ADDR_W-1:0] len_s, target_s;

    // Opcode byte arrives on mem_data during OP_CAP; afterwards it is held in opcode_q.
    assign dec_op_s = (state_q == OP_CAP) ? mem_data : opcode_q;

    bytecode_len u_len (
        .op        (dec_op_s),
        .argc      (argc_s),
        .is_branch (is_branch_s),
        .is_goto   (is_goto_s),
        .is_return (is_return_s),
        .is_legal  (is_legal_s)
    );

    assign len_s    = ADDR_W'(argc_s) + ADDR_W'(1'b1);
    assign target_s = instr_pc_q + ADDR_W'(signed'(arg_q));

    // Next-state, memory request and instruction-latch logic.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_pc_d = instr_pc_q;
        opcode_d   = opcode_q;
        arg_d      = arg_q;
        illegal_d  = illegal_q;
        mem_rd_s   = 1'b0;
        mem_addr_s = '0;
        case (state_q)
            IDLE, HALT: begin
                if (start) begin
                    pc_d      = start_addr;
                    illegal_d = 1'b0;
                    state_d   = OP_REQ;
                end else begin
                    state_d   = state_q;
                end
            end
            OP_REQ: begin
                mem_rd_s   = 1'b1;
                mem_addr_s = pc_q;
                state_d    = OP_CAP;
            end
            OP_CAP: begin
                opcode_d   = mem_data;
                instr_pc_d = pc_q;
                arg_d      = 16'h0000;
                if (!is_legal_s) begin
                    illegal_d = 1'b1;
                    state_d   = HALT;
                end else if (argc_s != 2'd0) begin
                    mem_rd_s   = 1'b1;
                    mem_addr_s = pc_q + ADDR_W'(1'b1);
                    state_d    = A1_CAP;
                end else begin
                    state_d = ISSUE;
                end
            end
            A1_CAP: begin
                arg_d = {8'h00, mem_data};
                if (argc_s == 2'd2) begin
                    mem_rd_s   = 1'b1;
                    mem_addr_s = pc_q + ADDR_W'(2'd2);
                    state_d    = A2_CAP;
                end else begin
                    state_d = ISSUE;
                end
            end
            A2_CAP: begin
                arg_d   = {arg_q[7:0], mem_data};
                state_d = ISSUE;
            end
            ISSUE: begin
                if (instr_ready) begin
                    if (is_return_s) begin
                        state_d = HALT;
                    end else if (is_goto_s || (is_branch_s && branch_taken)) begin
                        pc_d    = target_s;
                        state_d = OP_REQ;
                    end else begin
                        pc_d    = instr_pc_q + len_s;
                        state_d = OP_REQ;
                    end
                end else begin
                    state_d = ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            instr_pc_q <= '0;
            opcode_q   <= 8'h00;
            arg_q      <= 16'h0000;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_pc_q <= instr_pc_d;
            opcode_q   <= opcode_d;
            arg_q      <= arg_d;
            illegal_q  <= illegal_d;
        end
    end

    assign mem_rd      = mem_rd_s;
    assign mem_addr    = mem_addr_s;
    assign instr_valid = (state_q == ISSUE);
    assign busy        = (state_q != IDLE) && (state_q != HALT);
    assign halted      = (state_q == HALT);
    assign illegal     = illegal_q;
    assign opcode      = opcode_q;
    assign arg         = arg_q;
    assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_bytecode_fetch.sv
// Self-checking bench for bytecode_fetch: directed program snippets followed by random programs,
// all checked against an instruction-level reference model (honours FETCH_ILLEGAL_EN).
module tb_bytecode_fetch;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst_n, start, mem_rd, instr_valid, instr_ready, branch_taken;
    logic          busy, halted, illegal;
    logic [AW-1:0] start_addr, mem_addr, instr_pc;
    logic [7:0]    mem_data, opcode;
    logic [15:0]   arg;
    logic [7:0]    mem [0:4095];
    logic [7:0]    pool [0:11] = '{8'h04, 8'h10, 8'h11, 8'h15, 8'h60, 8'h84,
                                   8'h99, 8'h9F, 8'hA7, 8'hB1, 8'h36, 8'h00};
    int            n_cmp = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    bytecode_fetch #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .opcode(opcode),
        .arg(arg), .instr_pc(instr_pc), .branch_taken(branch_taken),
        .busy(busy), .halted(halted), .illegal(illegal)
    );

    // Synchronous program memory: data one cycle after the read strobe.
    always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_argc(input logic [7:0] op);
        if (op == 8'h11 || op == 8'h84 || (op >= 8'h99 && op <= 8'hA7)) return 2;
        if (op == 8'h10 || op == 8'h12 || op == 8'h15 || op == 8'h36 || op == 8'hBC) return 1;
        return 0;
    endfunction

    function automatic bit m_legal(input logic [7:0] op);
`ifdef FETCH_ILLEGAL_EN
        case (op) inside
            8'h00, [8'h02:8'h08], 8'h10, 8'h11, 8'h12, 8'h15, [8'h1A:8'h1D], 8'h36,
            [8'h3B:8'h3E], 8'h57, 8'h59, 8'h60, 8'h64, 8'h68, 8'h84, [8'h99:8'hA7],
            8'hAC, 8'hB0, 8'hB1, 8'hBC: return 1'b1;
            default: return 1'b0;
        endcase
`else
        return (op === op);
`endif
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"},  32'(instr_valid), 32'd0);
        check({tag, "_rd"},     32'(mem_rd),      32'd0);
        check({tag, "_addr"},   32'(mem_addr),    32'd0);
        check({tag, "_opcode"}, 32'(opcode),      32'd0);
        check({tag, "_arg"},    32'(arg),         32'd0);
        check({tag, "_ipc"},    32'(instr_pc),    32'd0);
        check({tag, "_busy"},   32'(busy),        32'd0);
        check({tag, "_halted"}, 32'(halted),      32'd0);
        check({tag, "_illegal"},32'(illegal),     32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; instr_ready = 1'b0; branch_taken = 1'b0; start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic start_at(input logic [AW-1:0] a);
        @(negedge clk);
        start = 1'b1; start_addr = a;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // One instruction: fetch address, latency, fields, optional stall, handshake, next pc.
    task automatic run_instr(input logic [AW-1:0] pc, input bit taken, input int hold,
                             output logic [AW-1:0] next_pc, output bit stop);
        logic [7:0]    op;
        logic [15:0]   exp_arg;
        logic [AW-1:0] p1, p2;
        int            ac, n;
        op = mem[pc]; ac = m_argc(op);
        p1 = pc + 12'd1; p2 = pc + 12'd2;
        exp_arg = (ac == 2) ? {mem[p1], mem[p2]} : (ac == 1) ? {8'h00, mem[p1]} : 16'h0000;
        stop = 1'b0; next_pc = pc;
        @(negedge clk);
        check("fetch_rd", 32'(mem_rd), 32'd1);
        check("fetch_addr", 32'(mem_addr), 32'(pc));
        if (!m_legal(op)) begin
            @(negedge clk);
            check("ill_novalid", 32'(instr_valid), 32'd0);
            @(negedge clk);
            check("ill_halted", 32'(halted), 32'd1);
            check("ill_flag", 32'(illegal), 32'd1);
            check("ill_ipc", 32'(instr_pc), 32'(pc));
            check("ill_busy", 32'(busy), 32'd0);
            check("ill_valid", 32'(instr_valid), 32'd0);
            stop = 1'b1;
            return;
        end
        n = 1;
        while (!instr_valid && n < 12) begin
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'(3 + ac));
        check("opcode", 32'(opcode), 32'(op));
        check("arg", 32'(arg), 32'(exp_arg));
        check("instr_pc", 32'(instr_pc), 32'(pc));
        check("issue_rd", 32'(mem_rd), 32'd0);
        check("issue_busy", 32'(busy), 32'd1);
        check("issue_illegal", 32'(illegal), 32'd0);
        for (int h = 0; h < hold; h++) begin
            start = (h == 0); start_addr = 12'h555;
            @(negedge clk);
            check("hold_valid", 32'(instr_valid), 32'd1);
            check("hold_rd", 32'(mem_rd), 32'd0);
            check("hold_opcode", 32'(opcode), 32'(op));
            check("hold_arg", 32'(arg), 32'(exp_arg));
        end
        start = 1'b0;
        instr_ready = 1'b1; branch_taken = taken;
        @(posedge clk);
        #1 instr_ready = 1'b0; branch_taken = 1'b0;
        if (op == 8'hAC || op == 8'hB0 || op == 8'hB1) begin
            @(negedge clk);
            check("ret_halted", 32'(halted), 32'd1);
            check("ret_busy", 32'(busy), 32'd0);
            check("ret_valid", 32'(instr_valid), 32'd0);
            check("ret_rd", 32'(mem_rd), 32'd0);
            stop = 1'b1;
        end else if (op == 8'hA7 || (op >= 8'h99 && op <= 8'hA6 && taken)) begin
            next_pc = pc + exp_arg[AW-1:0];
        end else begin
            next_pc = pc + AW'(ac + 1);
        end
    endtask

    // Run from the current address until a halt or the instruction budget runs out.
    task automatic run_prog(input logic [AW-1:0] a, input bit taken, input int max_n);
        logic [AW-1:0] pc, npc;
        bit            stop;
        pc = a; stop = 1'b0;
        start_at(a);
        for (int k = 0; k < max_n && !stop; k++) begin
            run_instr(pc, taken, 0, npc, stop);
            pc = npc;
        end
    endtask

    initial begin
        logic [AW-1:0] pc, npc;
        bit            stop;
        rst_n = 1'b0; start = 1'b0; start_addr = '0; instr_ready = 1'b0;
        branch_taken = 1'b0; mem_data = 8'h00;
        for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
        #12;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        mem[12'h010] = 8'h04; mem[12'h011] = 8'h05; mem[12'h012] = 8'h60; mem[12'h013] = 8'hB1;
        run_prog(12'h010, 1'b0, 4);

        mem[12'h000] = 8'h11; mem[12'h001] = 8'h12; mem[12'h002] = 8'h34; mem[12'h003] = 8'hB1;
        run_prog(12'h000, 1'b0, 2);
        mem[12'h000] = 8'h10; mem[12'h001] = 8'hFF; mem[12'h002] = 8'hB1;
        run_prog(12'h000, 1'b0, 2);

        mem[12'h020] = 8'hA7; mem[12'h021] = 8'hFF; mem[12'h022] = 8'hFC; mem[12'h01C] = 8'hAC;
        run_prog(12'h020, 1'b0, 2);

        mem[12'h030] = 8'h99; mem[12'h031] = 8'h00; mem[12'h032] = 8'h08;
        mem[12'h038] = 8'hB0; mem[12'h033] = 8'hB1;
        run_prog(12'h030, 1'b1, 2);
        run_prog(12'h030, 1'b0, 2);

        mem[12'h040] = 8'h15; mem[12'h041] = 8'h07; mem[12'h042] = 8'h60; mem[12'h043] = 8'hB1;
        start_at(12'h040);
        run_instr(12'h040, 1'b0, 5, npc, stop);
        run_instr(npc, 1'b1, 0, npc, stop);
        run_instr(npc, 1'b0, 0, npc, stop);

        mem[12'h050] = 8'h10; mem[12'h051] = 8'hAA;
        start_at(12'h050);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1 check_idle_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset_valid", 32'(instr_valid), 32'd0);
        check("post_reset_busy", 32'(busy), 32'd0);

        mem[12'hFFF] = 8'h10; mem[12'h000] = 8'h07; mem[12'h001] = 8'hB1;
        run_prog(12'hFFF, 1'b0, 2);

        mem[12'h060] = 8'hFE; mem[12'h061] = 8'hB1;
        start_at(12'h060);
        run_instr(12'h060, 1'b0, 0, npc, stop);
        if (!stop) run_instr(npc, 1'b0, 0, npc, stop);
        start_at(12'h061);
        check("illegal_cleared", 32'(illegal), 32'd0);
        run_instr(12'h061, 1'b0, 0, npc, stop);

        for (int r = 0; r < 10; r++) begin
            for (int a = 0; a < 4096; a++)
                mem[a] = ($urandom_range(3) != 0) ? pool[$urandom_range(11)] : 8'($urandom);
            do_reset();
            pc = 12'($urandom_range(4095));
            start_at(pc);
            stop = 1'b0;
            for (int k = 0; k < 20 && !stop; k++) begin
                run_instr(pc, 1'($urandom_range(1)), int'($urandom_range(2)), npc, stop);
                pc = npc;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
